// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths and FSM state encoding for the SRAM tester
package sram_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int SW_W   = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR1  = 3'd1,
        WR2  = 3'd2,
        RD1  = 3'd3,
        RD2  = 3'd4
    } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - two-cycle asynchronous SRAM access FSM with registered pin outputs
module sram_ctrl
    import sram_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              mem_i,
    input  logic              rw_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              data_valid_o,
    output logic [ADDR_W-1:0] sram_adr_o,
    inout  wire  [DATA_W-1:0] sram_dat_io,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_ce_n_o
);

    state_t              state_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                valid_q;
    logic                we_n_q;
    logic                oe_n_q;
    logic                ce_n_q;
    logic                drive_q;

    // FSM plus registered strobes; address and write data are frozen at start so
    // the top may change its address register mid-access without disturbing the pins.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_i) begin
                        adr_q  <= addr_i;
                        ce_n_q <= 1'b0;
                        if (rw_i) begin
                            wdata_q <= wdata_i;
                            we_n_q  <= 1'b0;
                            drive_q <= 1'b1;
                            state_q <= WR1;
                        end else begin
                            oe_n_q  <= 1'b0;
                            state_q <= RD1;
                        end
                    end
                end
                WR1: begin
                    state_q <= WR2;
                end
                WR2: begin
                    we_n_q  <= 1'b1;
                    ce_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                    state_q <= IDLE;
                end
                RD1: begin
                    state_q <= RD2;
                end
                RD2: begin
                    rdata_q <= sram_dat_io;
                    valid_q <= 1'b1;
                    oe_n_q  <= 1'b1;
                    ce_n_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    we_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    ce_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // drive_q is only set in write states, where oe_n stays high, so no contention.
    assign sram_dat_io  = drive_q ? wdata_q : {DATA_W{1'bz}};

    assign ready_o      = (state_q == IDLE);
    assign rdata_o      = rdata_q;
    assign data_valid_o = valid_q;
    assign sram_adr_o   = adr_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_ce_n_o  = ce_n_q;

endmodule

// File: rtl/sram_ctrl_tester.sv
// rtl/sram_ctrl_tester.sv - switch/button front end exercising the board SRAM
module sram_ctrl_tester
    import sram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [SW_W-1:0]   sw,
    input  logic [2:0]        btn,
    output logic [7:0]        led,
    output logic [ADDR_W-1:0] sram_adr,
    inout  wire  [DATA_W-1:0] sram_dat,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n,
    output logic              sram_ub,
    output logic              sram_lb
);

    logic [2:0]        btn_q;
    logic [2:0]        btn_prev_q;
    logic [2:0]        btn_edge;
    logic [ADDR_W-1:0] addr_reg_q;
    logic [7:0]        led_q;

    logic              ready;
    logic              start_wr;
    logic              start_rd;
    logic [DATA_W-1:0] rdata;
    logic              data_valid;
    logic              rdata_hi_unused;

    // Register the buttons and keep their previous value for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q      <= 3'b000;
            btn_prev_q <= 3'b000;
        end else begin
            btn_q      <= btn;
            btn_prev_q <= btn_q;
        end
    end

    assign btn_edge = btn_q & ~btn_prev_q;

    // Write has priority over a simultaneous read; edges while busy are simply lost.
    assign start_wr = btn_edge[1] & ready;
    assign start_rd = btn_edge[2] & ~btn_edge[1] & ready;

    // Address latch accepts btn0 at any time; LEDs follow each completed read.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg_q <= '0;
            led_q      <= 8'h00;
        end else begin
            if (btn_edge[0]) begin
                addr_reg_q <= {{(ADDR_W-SW_W){1'b0}}, sw};
            end
            if (data_valid) begin
                led_q <= rdata[7:0];
            end
        end
    end

    sram_ctrl u_ctrl (
        .clk_i        (clk),
        .reset_i      (reset),
        .mem_i        (start_wr | start_rd),
        .rw_i         (start_wr),
        .addr_i       (addr_reg_q),
        .wdata_i      ({{(DATA_W-SW_W){1'b0}}, sw}),
        .ready_o      (ready),
        .rdata_o      (rdata),
        .data_valid_o (data_valid),
        .sram_adr_o   (sram_adr),
        .sram_dat_io  (sram_dat),
        .sram_we_n_o  (sram_we_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_ce_n_o  (sram_ce_n)
    );

    assign rdata_hi_unused = ^rdata[DATA_W-1:8];

    assign led     = led_q;
    assign sram_ub = 1'b0;
    assign sram_lb = 1'b0;

endmodule

// File: tb/tb_sram_ctrl_tester.sv
// tb/tb_sram_ctrl_tester.sv - directed self-checking bench for sram_ctrl_tester
module tb_sram_ctrl_tester;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw;
    logic [2:0]  btn;
    wire  [7:0]  led;
    wire  [17:0] sram_adr;
    tri1  [15:0] sram_dat;
    wire         sram_we_n;
    wire         sram_oe_n;
    wire         sram_ce_n;
    wire         sram_ub;
    wire         sram_lb;

    logic [15:0] model_q;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cycles;
    int rd_cycles;

    always #5 clk = ~clk;

    // SRAM model: returns model_q whenever chip and output are enabled.
    assign sram_dat = (!sram_oe_n && !sram_ce_n) ? model_q : 16'bz;

    sram_ctrl_tester dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .sram_adr  (sram_adr),
        .sram_dat  (sram_dat),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .sram_ce_n (sram_ce_n),
        .sram_ub   (sram_ub),
        .sram_lb   (sram_lb)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        if (!sram_we_n) wr_cycles++;
        if (!sram_oe_n) rd_cycles++;
        n_checks++;
        if (!sram_oe_n && !sram_we_n) begin
            n_fail++;
            $display("FAIL contention: oe_n=%b we_n=%b, required not both low", sram_oe_n, sram_we_n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; sw = 8'h00; btn = 3'b000; model_q = 16'h0000;
        tick();
        n_checks++; if (sram_ce_n !== 1'b1) begin n_fail++; $display("FAIL reset_ce_n: got %b want 1", sram_ce_n); end
        n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
        n_checks++; if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b want 1", sram_oe_n); end
        n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h want 00", led); end
        n_checks++; if (sram_dat !== 16'hFFFF) begin n_fail++; $display("FAIL reset_bus_z: got %h want released (FFFF pulled)", sram_dat); end
        n_checks++; if (sram_adr !== 18'h00000) begin n_fail++; $display("FAIL reset_adr: got %h want 00000", sram_adr); end
        n_checks++; if ({sram_ub, sram_lb} !== 2'b00) begin n_fail++; $display("FAIL ub_lb: got %b want 00", {sram_ub, sram_lb}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_addr_latch;
        sw = 8'hF0; btn = 3'b001; wr_cycles = 0; rd_cycles = 0;
        repeat (7) tick();
        btn = 3'b000;
        tick();
        n_checks++; if (wr_cycles + rd_cycles != 0) begin n_fail++; $display("FAIL latch_no_access: got %0d access cycles want 0", wr_cycles + rd_cycles); end
        n_checks++; if (sram_ce_n !== 1'b1) begin n_fail++; $display("FAIL latch_ce_n: got %b want 1", sram_ce_n); end
        n_checks++; if (sram_adr !== 18'h00000) begin n_fail++; $display("FAIL latch_adr_idle: got %h want 00000", sram_adr); end
    endtask

    task automatic test_write;
        sw = 8'hFF; btn = 3'b010; wr_cycles = 0; rd_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (sram_we_n !== ((i == 1 || i == 2) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL write_we_n_cycle%0d: got %b want %b", i, sram_we_n, (i == 1 || i == 2) ? 1'b0 : 1'b1);
            end
            if (i == 1 || i == 2) begin
                n_checks++; if (sram_ce_n !== 1'b0) begin n_fail++; $display("FAIL write_ce_n_cycle%0d: got %b want 0", i, sram_ce_n); end
                n_checks++; if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL write_oe_n_cycle%0d: got %b want 1", i, sram_oe_n); end
                n_checks++; if (sram_adr !== 18'h000F0) begin n_fail++; $display("FAIL write_adr_cycle%0d: got %h want 000F0", i, sram_adr); end
                n_checks++; if (sram_dat !== 16'h00FF) begin n_fail++; $display("FAIL write_dat_cycle%0d: got %h want 00FF", i, sram_dat); end
            end
        end
        btn = 3'b000;
        tick();
        n_checks++; if (wr_cycles != 2) begin n_fail++; $display("FAIL write_count: got %0d want 2", wr_cycles); end
        n_checks++; if (rd_cycles != 0) begin n_fail++; $display("FAIL write_no_read: got %0d want 0", rd_cycles); end
        n_checks++; if (sram_dat !== 16'hFFFF) begin n_fail++; $display("FAIL write_bus_released: got %h want FFFF", sram_dat); end
        n_checks++; if (sram_adr !== 18'h000F0) begin n_fail++; $display("FAIL write_adr_hold: got %h want 000F0", sram_adr); end
    endtask

    task automatic test_read;
        model_q = 16'h00F0; sw = 8'h5A; btn = 3'b100; wr_cycles = 0; rd_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (sram_oe_n !== ((i == 1 || i == 2) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL read_oe_n_cycle%0d: got %b want %b", i, sram_oe_n, (i == 1 || i == 2) ? 1'b0 : 1'b1);
            end
            if (i == 1) begin
                n_checks++; if (sram_adr !== 18'h000F0) begin n_fail++; $display("FAIL read_adr: got %h want 000F0", sram_adr); end
            end
            if (i == 3) begin
                n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL read_led_early: got %h want 00", led); end
            end
            if (i == 4) begin
                n_checks++; if (led !== 8'hF0) begin n_fail++; $display("FAIL read_led_cycle4: got %h want F0", led); end
            end
        end
        btn = 3'b000; model_q = 16'h1234;
        repeat (3) tick();
        n_checks++; if (led !== 8'hF0) begin n_fail++; $display("FAIL read_led_hold: got %h want F0", led); end
        n_checks++; if (rd_cycles != 2) begin n_fail++; $display("FAIL read_count: got %0d want 2", rd_cycles); end
        n_checks++; if (wr_cycles != 0) begin n_fail++; $display("FAIL read_no_write: got %0d want 0", wr_cycles); end
    endtask

    task automatic test_simultaneous;
        model_q = 16'h00AA; sw = 8'h33; btn = 3'b110; wr_cycles = 0; rd_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 2) begin
                n_checks++; if (sram_dat !== 16'h0033) begin n_fail++; $display("FAIL simul_dat: got %h want 0033", sram_dat); end
            end
        end
        btn = 3'b000;
        tick();
        n_checks++; if (wr_cycles != 2) begin n_fail++; $display("FAIL simul_write_count: got %0d want 2", wr_cycles); end
        n_checks++; if (rd_cycles != 0) begin n_fail++; $display("FAIL simul_read_dropped: got %0d want 0", rd_cycles); end
        n_checks++; if (led !== 8'hF0) begin n_fail++; $display("FAIL simul_led: got %h want F0", led); end
    endtask

    task automatic test_back_to_back;
        // btn2 and btn0 edges land in WR1: read dropped, address latch taken.
        model_q = 16'h0011; sw = 8'h44; btn = 3'b010; wr_cycles = 0; rd_cycles = 0;
        tick();
        btn = 3'b111;
        tick();
        n_checks++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL b2b_wr1: got we_n=%b want 0", sram_we_n); end
        sw = 8'h77;
        tick();
        n_checks++; if (sram_adr !== 18'h000F0) begin n_fail++; $display("FAIL b2b_adr_held: got %h want 000F0", sram_adr); end
        n_checks++; if (sram_dat !== 16'h0044) begin n_fail++; $display("FAIL b2b_dat_held: got %h want 0044", sram_dat); end
        repeat (6) tick();
        btn = 3'b000;
        tick();
        n_checks++; if (rd_cycles != 0) begin n_fail++; $display("FAIL b2b_no_read: got %0d want 0", rd_cycles); end
        n_checks++; if (wr_cycles != 2) begin n_fail++; $display("FAIL b2b_write_count: got %0d want 2", wr_cycles); end
        model_q = 16'h00C3; btn = 3'b100; rd_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) begin
                n_checks++; if (sram_adr !== 18'h00077) begin n_fail++; $display("FAIL b2b_new_adr: got %h want 00077", sram_adr); end
            end
        end
        btn = 3'b000;
        tick();
        n_checks++; if (led !== 8'hC3) begin n_fail++; $display("FAIL b2b_led: got %h want C3", led); end
        n_checks++; if (rd_cycles != 2) begin n_fail++; $display("FAIL b2b_read_count: got %0d want 2", rd_cycles); end
    endtask

    task automatic test_reset_mid;
        sw = 8'h55; btn = 3'b010; wr_cycles = 0;
        tick();
        tick();
        n_checks++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL mid_in_wr1: got we_n=%b want 0", sram_we_n); end
        reset = 1'b1; btn = 3'b000;
        tick();
        n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL mid_we_n: got %b want 1", sram_we_n); end
        n_checks++; if (sram_ce_n !== 1'b1) begin n_fail++; $display("FAIL mid_ce_n: got %b want 1", sram_ce_n); end
        n_checks++; if (sram_dat !== 16'hFFFF) begin n_fail++; $display("FAIL mid_bus_z: got %h want FFFF", sram_dat); end
        n_checks++; if (sram_adr !== 18'h00000) begin n_fail++; $display("FAIL mid_adr: got %h want 00000", sram_adr); end
        n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL mid_led: got %h want 00", led); end
        reset = 1'b0; wr_cycles = 0; rd_cycles = 0;
        repeat (5) tick();
        n_checks++; if (wr_cycles + rd_cycles != 0) begin n_fail++; $display("FAIL mid_no_retry: got %0d access cycles want 0", wr_cycles + rd_cycles); end
    endtask

    initial begin
        reset = 1'b1; sw = 8'h00; btn = 3'b000; model_q = 16'h0000;
        wr_cycles = 0; rd_cycles = 0;
        test_reset();
        test_addr_latch();
        test_write();
        test_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
